fpga_temp_monitor: RTL and testbench

- Sits directly downstream of the FPGA die-temperature sensor stage and consumes its 8-bit temperature code plus a one-cycle sample strobe.
- Smooths samples with a power-of-two moving average and tracks raw min/max peaks.
- Classifies the averaged value into NORMAL/WARN/ALARM with hysteresis and consecutive-sample debounce.
- Drives status flags for board logic and host readout.

---
 rtl/fpga_temp_pkg.sv | 18 +
 rtl/temp_moving_avg.sv | 51 +++++
 rtl/fpga_temp_monitor.sv | 104 ++++++++++
 tb/tb_fpga_temp_monitor.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_temp_pkg.sv
// Shared types and default thresholds for the FPGA die-temperature monitor.
package fpga_temp_pkg;

  typedef logic [7:0] temp_code_t;

  typedef enum logic [1:0] {
    TS_NORMAL = 2'd0,
    TS_WARN   = 2'd1,
    TS_ALARM  = 2'd2
  } temp_state_e;

  localparam temp_code_t TEMP_WARN_DEF  = 8'd85;
  localparam temp_code_t TEMP_ALARM_DEF = 8'd100;
  localparam temp_code_t TEMP_HYST_DEF  = 8'd5;
  localparam int TEMP_AVG_LOG2_DEF      = 2;
  localparam int TEMP_DEBOUNCE_DEF      = 3;

endpackage

// File: rtl/temp_moving_avg.sv
// Power-of-two moving average over a shift-register window; pulses avg_valid
// the cycle after every accepted sample once the window has filled.
module temp_moving_avg
  import fpga_temp_pkg::*;
#(
  parameter int AVG_LOG2 = TEMP_AVG_LOG2_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  output logic [7:0] avg,
  output logic       avg_valid
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = 8 + AVG_LOG2;
  localparam int FW = AVG_LOG2 + 1;

  temp_code_t      window [N];
  logic [SW-1:0]   sum;
  logic [SW-1:0]   sum_next;
  logic [FW-1:0]   fill;

  // The sum always equals the window contents, so the wrap of the
  // intermediate subtraction cancels out and the result never overflows.
  assign sum_next = sum + SW'(sample) - SW'(window[N-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) window[i] <= '0;
      sum       <= '0;
      fill      <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (sample_valid) begin
        window[0] <= sample;
        for (int i = 1; i < N; i++) window[i] <= window[i-1];
        sum <= sum_next;
        if (fill != FW'(N)) fill <= fill + 1'b1;
        if (fill >= FW'(N - 1)) begin
          avg       <= sum_next[SW-1:AVG_LOG2];
          avg_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fpga_temp_monitor.sv
// Die-temperature monitor: moving average, raw min/max peaks, and a
// NORMAL/WARN/ALARM classifier with downward hysteresis and debounce.
module fpga_temp_monitor
  import fpga_temp_pkg::*;
#(
  parameter int         AVG_LOG2 = TEMP_AVG_LOG2_DEF,
  parameter temp_code_t WARN_C   = TEMP_WARN_DEF,
  parameter temp_code_t ALARM_C  = TEMP_ALARM_DEF,
  parameter temp_code_t HYST_C   = TEMP_HYST_DEF,
  parameter int         DEBOUNCE = TEMP_DEBOUNCE_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_Temperature,
  input  logic       i_Temp_Valid,
  input  logic       i_Clear_Peaks,
  output logic [7:0] o_Avg_Temperature,
  output logic       o_Avg_Valid,
  output logic [7:0] o_Max_Temperature,
  output logic [7:0] o_Min_Temperature,
  output logic [1:0] o_State,
  output logic       o_Warn,
  output logic       o_Alarm
);

  localparam logic [8:0] ALARM_9    = {1'b0, ALARM_C};
  localparam logic [8:0] WARN_9     = {1'b0, WARN_C};
  localparam logic [8:0] ALARM_LO_9 = {1'b0, ALARM_C} - {1'b0, HYST_C};
  localparam logic [8:0] WARN_LO_9  = {1'b0, WARN_C} - {1'b0, HYST_C};
  localparam logic [3:0] DEB_4      = 4'(DEBOUNCE);

  temp_state_e state;
  temp_state_e target;
  temp_state_e cand;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic [8:0]  avg_9;

  // i_Temp_Valid is a one-cycle strobe with no back-pressure: a sample is
  // taken in every cycle it is high, including back-to-back cycles.
  temp_moving_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk          (i_Clk),
    .rst          (i_Rst),
    .sample       (i_Temperature),
    .sample_valid (i_Temp_Valid),
    .avg          (o_Avg_Temperature),
    .avg_valid    (o_Avg_Valid)
  );

  assign avg_9   = {1'b0, o_Avg_Temperature};
  assign o_State = state;

  always_comb begin
    target = TS_NORMAL;
    if (avg_9 >= ALARM_9)                                          target = TS_ALARM;
    else if (state == TS_ALARM && avg_9 >= ALARM_LO_9)             target = TS_ALARM;
    else if (avg_9 >= WARN_9)                                      target = TS_WARN;
    else if (state inside {TS_WARN, TS_ALARM} && avg_9 >= WARN_LO_9) target = TS_WARN;
  end

  assign cnt_next = (target == cand) ? cnt + 4'd1 : 4'd1;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state   <= TS_NORMAL;
      cand    <= TS_NORMAL;
      cnt     <= '0;
      o_Warn  <= 1'b0;
      o_Alarm <= 1'b0;
    end else if (o_Avg_Valid) begin
      if (target == state) begin
        cnt <= '0;
      end else begin
        cand <= target;
        if (cnt_next == DEB_4) begin
          state   <= target;
          o_Warn  <= (target != TS_NORMAL);
          o_Alarm <= (target == TS_ALARM);
          cnt     <= '0;
        end else begin
          cnt <= cnt_next;
        end
      end
    end
  end

  // A clear that coincides with a sample seeds both peaks with that sample.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Max_Temperature <= 8'd0;
      o_Min_Temperature <= 8'd255;
    end else if (i_Clear_Peaks && i_Temp_Valid) begin
      o_Max_Temperature <= i_Temperature;
      o_Min_Temperature <= i_Temperature;
    end else if (i_Clear_Peaks) begin
      o_Max_Temperature <= 8'd0;
      o_Min_Temperature <= 8'd255;
    end else if (i_Temp_Valid) begin
      if (i_Temperature > o_Max_Temperature) o_Max_Temperature <= i_Temperature;
      if (i_Temperature < o_Min_Temperature) o_Min_Temperature <= i_Temperature;
    end
  end

endmodule

// File: tb/tb_fpga_temp_monitor.sv
// Directed bench for fpga_temp_monitor: a sample-queue model checked every
// cycle, plus hand-computed literal pins along the test plan.
module tb_fpga_temp_monitor;

  localparam int N     = 4;
  localparam int WARN  = 85;
  localparam int ALARM = 100;
  localparam int HYST  = 5;
  localparam int DEB   = 3;

  logic       clk;
  logic       rst;
  logic [7:0] temperature;
  logic       temp_valid;
  logic       clear_peaks;
  logic [7:0] avg;
  logic       avg_valid;
  logic [7:0] max_t;
  logic [7:0] min_t;
  logic [1:0] state;
  logic       warn;
  logic       alarm;

  int checks   = 0;
  int failures = 0;

  // model state
  int         win[$];
  logic [7:0] exp_q[$];
  int         m_avg   = 0;
  bit         m_vld   = 0;
  int         m_max   = 0;
  int         m_min   = 255;
  int         m_state = 0;
  int         m_cand  = 0;
  int         m_cnt   = 0;

  fpga_temp_monitor dut (
    .i_Clk             (clk),
    .i_Rst             (rst),
    .i_Temperature     (temperature),
    .i_Temp_Valid      (temp_valid),
    .i_Clear_Peaks     (clear_peaks),
    .o_Avg_Temperature (avg),
    .o_Avg_Valid       (avg_valid),
    .o_Max_Temperature (max_t),
    .o_Min_Temperature (min_t),
    .o_State           (state),
    .o_Warn            (warn),
    .o_Alarm           (alarm)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int target_of(input int a, input int s);
    if (a >= ALARM) return 2;
    if (s == 2 && a >= ALARM - HYST) return 2;
    if (a >= WARN) return 1;
    if (s >= 1 && a >= WARN - HYST) return 1;
    return 0;
  endfunction

  // model: classify the average shown last cycle, then absorb this cycle's inputs
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      win.delete();
      exp_q.delete();
      m_avg = 0; m_vld = 0; m_max = 0; m_min = 255;
      m_state = 0; m_cand = 0; m_cnt = 0;
    end else begin
      if (m_vld) begin
        int t;
        t = target_of(m_avg, m_state);
        if (t == m_state) m_cnt = 0;
        else begin
          if (t == m_cand) m_cnt++;
          else begin
            m_cand = t;
            m_cnt  = 1;
          end
          if (m_cnt == DEB) begin
            m_state = t;
            m_cnt   = 0;
          end
        end
      end
      m_vld = 0;
      if (temp_valid) begin
        win.push_back(int'(temperature));
        if (win.size() > N) void'(win.pop_front());
        if (win.size() == N) begin
          int s;
          s = 0;
          foreach (win[i]) s += win[i];
          m_avg = s / N;
          m_vld = 1;
          exp_q.push_back(8'(m_avg));
        end
      end
      if (clear_peaks && temp_valid) begin
        m_max = int'(temperature);
        m_min = int'(temperature);
      end else if (clear_peaks) begin
        m_max = 0;
        m_min = 255;
      end else if (temp_valid) begin
        if (int'(temperature) > m_max) m_max = int'(temperature);
        if (int'(temperature) < m_min) m_min = int'(temperature);
      end
    end
  end

  // compare every cycle on the falling edge
  initial forever begin
    @(negedge clk);
    chk("avg_valid", avg_valid, m_vld);
    chk("avg_value", avg, m_avg);
    if (avg_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL avg_pulse: got pulse avg=%0d expected no pulse at %0t", avg, $time);
      end else begin
        chk("avg_pulse", avg, exp_q.pop_front());
      end
    end
    chk("max", max_t, m_max);
    chk("min", min_t, m_min);
    chk("state", state, m_state);
    chk("warn", warn, m_state != 0);
    chk("alarm", alarm, m_state == 2);
  end

  // driver tasks
  task automatic drive(input bit v, input int t, input bit c);
    temp_valid  = v;
    temperature = 8'(t);
    clear_peaks = c;
    @(negedge clk);
  endtask

  task automatic feed(input int t);
    drive(1, t, 0);
    drive(0, 0, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) drive(0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    int pat[9];
    rst = 1'b1; temp_valid = 1'b0; temperature = 8'd0; clear_peaks = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_avg", avg, 0);
    chk("rst_valid", avg_valid, 0);
    chk("rst_max", max_t, 0);
    chk("rst_min", min_t, 255);
    chk("rst_state", state, 0);
    chk("rst_warn", warn, 0);
    chk("rst_alarm", alarm, 0);
    rst = 1'b0;

    // fill and average, spaced strobes
    drive(1, 10, 0); chk("fill1_vld", avg_valid, 0); drive(0, 0, 0);
    drive(1, 20, 0); chk("fill2_vld", avg_valid, 0); drive(0, 0, 0);
    drive(1, 30, 0); chk("fill3_vld", avg_valid, 0); drive(0, 0, 0);
    drive(1, 40, 0); chk("fill4_vld", avg_valid, 1); chk("fill4_avg", avg, 25);
    drive(0, 0, 0);  chk("hold_vld", avg_valid, 0); chk("hold_avg", avg, 25);
    drive(1, 50, 0); chk("fill5_avg", avg, 35);
    drive(0, 0, 0);  chk("fill_max", max_t, 50); chk("fill_min", min_t, 10);

    // same samples back-to-back
    do_reset(2);
    drive(1, 10, 0); drive(1, 20, 0); drive(1, 30, 0);
    chk("b2b3_vld", avg_valid, 0);
    drive(1, 40, 0); chk("b2b4_vld", avg_valid, 1); chk("b2b4_avg", avg, 25);
    drive(1, 50, 0); chk("b2b5_vld", avg_valid, 1); chk("b2b5_avg", avg, 35);
    drive(0, 0, 0);  chk("b2b_max", max_t, 50); chk("b2b_min", min_t, 10);

    // WARN entry: averages of 90 start at the 4th sample
    do_reset(2);
    for (int i = 1; i <= 6; i++) begin
      feed(90);
      if (i == 5) chk("warn_after2", state, 0);
    end
    chk("warn_after3", state, 1);
    chk("warn_flag", warn, 1);

    // raw samples chosen so the averages run 90,90,80,90,90,90
    do_reset(2);
    pat = '{90, 90, 90, 90, 90, 50, 130, 90, 90};
    for (int i = 0; i < 9; i++) begin
      drive(1, pat[i], 0);
      if (i == 5) chk("pat_avg80", avg, 80);
      drive(0, 0, 0);
      if (i == 7) chk("pat_not_yet", state, 0);
    end
    chk("pat_warn", state, 1);

    // ALARM hysteresis path (averages 103,97,101,105,105)
    repeat (4) feed(105);
    chk("alarm_pre", state, 1);
    feed(105);
    chk("alarm_in", state, 2);
    chk("alarm_flag", alarm, 1);
    repeat (10) feed(97);
    chk("alarm_hold97", state, 2);
    repeat (4) feed(94);
    chk("alarm_pre94", state, 2);
    feed(94);
    chk("warn_from_alarm", state, 1);
    chk("alarm_flag_off", alarm, 0);
    repeat (5) feed(82);
    chk("warn_hold82", state, 1);
    repeat (4) feed(79);
    chk("warn_pre79", state, 1);
    feed(79);
    chk("normal_back", state, 0);
    repeat (4) feed(110);
    chk("direct_pre", state, 0);
    feed(110);
    chk("direct_alarm", state, 2);

    // peaks clear
    drive(0, 0, 1);
    chk("clr_max", max_t, 0);
    chk("clr_min", min_t, 255);
    drive(1, 60, 1);
    chk("clr_s_max", max_t, 60);
    chk("clr_s_min", min_t, 60);
    drive(0, 0, 0);
    feed(70);
    chk("post_clr_max", max_t, 70);
    chk("post_clr_min", min_t, 60);

    // async reset between debounce counts 2 and 3
    do_reset(2);
    repeat (5) feed(90);
    #2 rst = 1'b1;
    #1;
    chk("arst_avg", avg, 0);
    chk("arst_valid", avg_valid, 0);
    chk("arst_max", max_t, 0);
    chk("arst_min", min_t, 255);
    chk("arst_state", state, 0);
    @(negedge clk);
    drive(0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 90, 0);
      chk("arst_refill_vld", avg_valid, 0);
      drive(0, 0, 0);
      chk("arst_refill_state", state, 0);
    end
    feed(90);
    chk("arst_refill_avg", avg, 90);
    chk("arst_state_end", state, 0);

    drive(0, 0, 0);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
